// File: rtl/admo_alu_issue_pkg.sv
// Shared defines for the ADMO ALU issue unit: widths, RV32I opcodes and ALU operator codes.
// ALU operator code is {funct7[5], funct3}; bit 3 distinguishes SUB from ADD and SRA from SRL.
package admo_alu_issue_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int OP_WIDTH   = 4;
    localparam int REG_WIDTH  = 5;

    typedef logic [OP_WIDTH-1:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 4'b0000;
    localparam alu_op_t ALU_SUB = 4'b1000;
    localparam alu_op_t ALU_SLL = 4'b0001;
    localparam alu_op_t ALU_LTS = 4'b0010;
    localparam alu_op_t ALU_LTU = 4'b0011;
    localparam alu_op_t ALU_XOR = 4'b0100;
    localparam alu_op_t ALU_SRL = 4'b0101;
    localparam alu_op_t ALU_SRA = 4'b1101;
    localparam alu_op_t ALU_OR  = 4'b0110;
    localparam alu_op_t ALU_AND = 4'b0111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // One buffered entry: {operand_a, operand_b, operator, rd, rd_we}.
    function automatic int payload_width(input int data_width);
        return 2 * data_width + OP_WIDTH + REG_WIDTH + 1;
    endfunction

    localparam int PAYLOAD_W = payload_width(DATA_WIDTH);

endpackage

// File: rtl/admo_alu_issue_decode.sv
// Combinational RV32I integer decoder producing ALU operands, operator, rd and an illegal flag.
// Optional macro ADMO_ALU_ISSUE_LTU_EN enables SLTU/SLTIU; otherwise funct3 011 is illegal.
module admo_alu_issue_decode
    import admo_alu_issue_pkg::*;
#(
    parameter int DATA_WIDTH = admo_alu_issue_pkg::DATA_WIDTH
) (
    input  logic [31:0]           instr,
    input  logic [31:0]           pc,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    output logic [DATA_WIDTH-1:0] operand_a,
    output logic [DATA_WIDTH-1:0] operand_b,
    output alu_op_t               operator,
    output logic [REG_WIDTH-1:0]  rd,
    output logic                  rd_we,
    output logic                  illegal
);

`ifdef ADMO_ALU_ISSUE_LTU_EN
    localparam bit LTU_EN = 1'b1;
`else
    localparam bit LTU_EN = 1'b0;
`endif

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rd     = instr[11:7];

    always_comb begin
        operand_a = '0;
        operand_b = '0;
        operator  = ALU_ADD;
        illegal   = 1'b0;

        case (opcode)
            OPC_OP: begin
                operand_a = rs1_data;
                operand_b = rs2_data;
                operator  = {instr[30], funct3};
                if (funct7 == 7'b0000000) begin
                    illegal = 1'b0;
                end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    illegal = 1'b0;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                operand_a = rs1_data;
                operand_b = DATA_WIDTH'($signed(instr[31:20]));
                operator  = {1'b0, funct3};
                // Shifts reuse the upper immediate bits as funct7; only bit 30 may be set, and only for SRAI.
                if (funct3 == 3'b001) begin
                    operand_b = DATA_WIDTH'(instr[24:20]);
                    illegal   = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    operand_b = DATA_WIDTH'(instr[24:20]);
                    operator  = {instr[30], funct3};
                    illegal   = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                end
            end
            OPC_LUI: begin
                operand_b = DATA_WIDTH'($signed({instr[31:12], 12'b0}));
            end
            OPC_AUIPC: begin
                operand_a = DATA_WIDTH'(pc);
                operand_b = DATA_WIDTH'($signed({instr[31:12], 12'b0}));
            end
            default: begin
                illegal = 1'b1;
            end
        endcase

        if (!LTU_EN && funct3 == 3'b011 && (opcode == OPC_OP || opcode == OPC_OP_IMM)) begin
            illegal = 1'b1;
        end

        rd_we = !illegal && (rd != '0);
    end

endmodule

// File: rtl/admo_alu_issue.sv
// Execute-stage issue unit: decodes into a two-entry skid buffer feeding the ALU operand port.
// Upstream ready is a flop so the accept path never depends on downstream ready.
module admo_alu_issue
    import admo_alu_issue_pkg::*;
#(
    parameter int DATA_WIDTH = admo_alu_issue_pkg::DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [31:0]           instr_i,
    input  logic [31:0]           pc_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] operand_a_o,
    output logic [DATA_WIDTH-1:0] operand_b_o,
    output logic [OP_WIDTH-1:0]   operator_o,
    output logic [REG_WIDTH-1:0]  rd_o,
    output logic                  rd_we_o,
    output logic                  illegal_o
);

    localparam int PW = payload_width(DATA_WIDTH);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]            state_q;
    logic                  in_ready_q;
    logic                  illegal_q;
    logic [PW-1:0]         main_q;
    logic [PW-1:0]         skid_q;

    logic [DATA_WIDTH-1:0] dec_a;
    logic [DATA_WIDTH-1:0] dec_b;
    alu_op_t               dec_op;
    logic [REG_WIDTH-1:0]  dec_rd;
    logic                  dec_we;
    logic                  dec_illegal;
    logic [PW-1:0]         dec_payload;

    logic                  accept;
    logic                  push;
    logic                  pop;

    admo_alu_issue_decode #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_decode (
        .instr     (instr_i),
        .pc        (pc_i),
        .rs1_data  (rs1_data_i),
        .rs2_data  (rs2_data_i),
        .operand_a (dec_a),
        .operand_b (dec_b),
        .operator  (dec_op),
        .rd        (dec_rd),
        .rd_we     (dec_we),
        .illegal   (dec_illegal)
    );

    assign dec_payload = {dec_a, dec_b, dec_op, dec_rd, dec_we};

    assign accept = in_valid_i && in_ready_q;
    assign push   = accept && !dec_illegal;
    assign pop    = out_valid_o && out_ready_i;

    // Illegal instructions complete the handshake but never enter the buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            illegal_q  <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush_i) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            illegal_q  <= 1'b0;
        end else begin
            illegal_q <= accept && dec_illegal;
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        main_q  <= dec_payload;
                        state_q <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_q <= dec_payload;
                    end else if (push) begin
                        skid_q     <= dec_payload;
                        state_q    <= ST_TWO;
                        in_ready_q <= 1'b0;
                    end else if (pop) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        main_q     <= skid_q;
                        state_q    <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q != ST_EMPTY);
    assign illegal_o   = illegal_q;
    assign {operand_a_o, operand_b_o, operator_o, rd_o, rd_we_o} = main_q;

endmodule

// File: tb/tb_admo_alu_issue.sv
// Self-checking bench for admo_alu_issue: directed test-plan steps followed by random traffic
// compared against a queue-based reference model of the decoder and two-deep buffer.
module tb_admo_alu_issue;

`ifdef ADMO_ALU_ISSUE_LTU_EN
    localparam bit LTU_EN = 1'b1;
`else
    localparam bit LTU_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        we;
    } entry_t;

    logic        clk_i;
    logic        rst_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] operand_a_o;
    logic [31:0] operand_b_o;
    logic [3:0]  operator_o;
    logic [4:0]  rd_o;
    logic        rd_we_o;
    logic        illegal_o;

    int     n_checks;
    int     n_fail;
    entry_t model_q[$];
    logic   exp_illegal;

    admo_alu_issue dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .instr_i     (instr_i),
        .pc_i        (pc_i),
        .rs1_data_i  (rs1_data_i),
        .rs2_data_i  (rs2_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .operand_a_o (operand_a_o),
        .operand_b_o (operand_b_o),
        .operator_o  (operator_o),
        .rd_o        (rd_o),
        .rd_we_o     (rd_we_o),
        .illegal_o   (illegal_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference decode written from the instruction-set rules, one mnemonic group at a time.
    function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] pcv,
                                       input logic [31:0] r1, input logic [31:0] r2,
                                       output bit legal, output entry_t e);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        int         imm;
        opc   = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        imm   = $signed(ins[31:20]);
        e     = '0;
        e.rd  = ins[11:7];
        legal = 1'b0;
        if (opc == 7'h33) begin
            e.a   = r1;
            e.b   = r2;
            e.op  = {ins[30], f3};
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            if (f3 == 3'd3 && !LTU_EN) legal = 1'b0;
        end else if (opc == 7'h13) begin
            e.a = r1;
            if (f3 == 3'd1) begin
                e.b   = 32'(ins[24:20]);
                e.op  = 4'b0001;
                legal = (f7 == 7'h00);
            end else if (f3 == 3'd5) begin
                e.b   = 32'(ins[24:20]);
                e.op  = (f7 == 7'h20) ? 4'b1101 : 4'b0101;
                legal = (f7 == 7'h00) || (f7 == 7'h20);
            end else begin
                e.b   = imm;
                e.op  = {1'b0, f3};
                legal = !(f3 == 3'd3 && !LTU_EN);
            end
        end else if (opc == 7'h37) begin
            e.b   = ins & 32'hFFFF_F000;
            legal = 1'b1;
        end else if (opc == 7'h17) begin
            e.a   = pcv;
            e.b   = ins & 32'hFFFF_F000;
            legal = 1'b1;
        end
        e.we = legal && (e.rd != 5'd0);
        if (!legal) e = '0;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check_output("out_valid", 32'(out_valid_o), 32'(model_q.size() > 0));
        check_output("in_ready", 32'(in_ready_o), 32'(model_q.size() < 2));
        check_output("illegal", 32'(illegal_o), 32'(exp_illegal));
        if (model_q.size() > 0) begin
            check_output("operand_a", operand_a_o, model_q[0].a);
            check_output("operand_b", operand_b_o, model_q[0].b);
            check_output("operator", 32'(operator_o), 32'(model_q[0].op));
            check_output("rd", 32'(rd_o), 32'(model_q[0].rd));
            check_output("rd_we", 32'(rd_we_o), 32'(model_q[0].we));
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge and compare just after it.
    task automatic apply_stimulus(input logic iv, input logic [31:0] ins, input logic [31:0] pcv,
                                  input logic [31:0] r1, input logic [31:0] r2,
                                  input logic ordy, input logic fl);
        bit     legal;
        bit     acc;
        entry_t e;
        in_valid_i  = iv;
        instr_i     = ins;
        pc_i        = pcv;
        rs1_data_i  = r1;
        rs2_data_i  = r2;
        out_ready_i = ordy;
        flush_i     = fl;
        ref_decode(ins, pcv, r1, r2, legal, e);
        acc = iv && (model_q.size() < 2);
        if (fl) begin
            model_q.delete();
            exp_illegal = 1'b0;
        end else begin
            if (model_q.size() > 0 && ordy) void'(model_q.pop_front());
            exp_illegal = acc && !legal;
            if (acc && legal) model_q.push_back(e);
        end
        @(posedge clk_i);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        in_valid_i = 1'b0;
        flush_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        model_q.delete();
        exp_illegal = 1'b0;
        check_output("rst_out_valid", 32'(out_valid_o), 32'd0);
        check_output("rst_in_ready", 32'(in_ready_o), 32'd1);
        check_output("rst_illegal", 32'(illegal_o), 32'd0);
        check_output("rst_operand_a", operand_a_o, 32'd0);
        check_output("rst_operand_b", operand_b_o, 32'd0);
        check_output("rst_fields", {23'd0, operator_o, rd_o}, 32'd0);
        check_output("rst_rd_we", 32'(rd_we_o), 32'd0);
        rst_i = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  f7;
        int          kind;
        w    = $urandom;
        kind = $urandom_range(0, 7);
        case ($urandom_range(0, 2))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = w[31:25];
        endcase
        case (kind)
            0, 1:    rand_instr = {f7, w[24:7], 7'h33};
            2, 3:    rand_instr = {f7, w[24:7], 7'h13};
            4:       rand_instr = {w[31:7], 7'h37};
            5:       rand_instr = {w[31:7], 7'h17};
            6:       rand_instr = w;
            default: rand_instr = {7'h00, w[24:7], 7'h33};
        endcase
    endfunction

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        exp_illegal = 1'b0;
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        instr_i     = '0;
        pc_i        = '0;
        rs1_data_i  = '0;
        rs2_data_i  = '0;
        out_ready_i = 1'b1;
        $display("[TB] start, LTU_EN=%0d", LTU_EN);
        do_reset();

        // ADD x3,x1,x2
        apply_stimulus(1'b1, 32'h002081B3, 32'h100, 32'd5, 32'd7, 1'b1, 1'b0);
        check_output("add_a", operand_a_o, 32'd5);
        check_output("add_b", operand_b_o, 32'd7);
        check_output("add_op", 32'(operator_o), 32'h0);
        check_output("add_rd", 32'(rd_o), 32'd3);
        check_output("add_we", 32'(rd_we_o), 32'd1);

        // SRAI x1,x2,3
        apply_stimulus(1'b1, 32'h40315093, 32'h104, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
        check_output("srai_a", operand_a_o, 32'h8000_0000);
        check_output("srai_b", operand_b_o, 32'd3);
        check_output("srai_op", 32'(operator_o), 32'hD);

        // LUI x5,0x12345
        apply_stimulus(1'b1, 32'h123452B7, 32'h108, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0);
        check_output("lui_a", operand_a_o, 32'd0);
        check_output("lui_b", operand_b_o, 32'h1234_5000);
        check_output("lui_rd", 32'(rd_o), 32'd5);
        apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_output("drain_valid", 32'(out_valid_o), 32'd0);

        // Back-pressure with three back-to-back ADDs to x1, x2, x3
        apply_stimulus(1'b1, 32'h002080B3, 32'h200, 32'd11, 32'd1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h00208133, 32'h204, 32'd22, 32'd2, 1'b0, 1'b0);
        check_output("bp_in_ready_low", 32'(in_ready_o), 32'd0);
        apply_stimulus(1'b1, 32'h002081B3, 32'h208, 32'd33, 32'd3, 1'b0, 1'b0);
        check_output("bp_hold_a", operand_a_o, 32'd11);
        apply_stimulus(1'b1, 32'h002081B3, 32'h208, 32'd33, 32'd3, 1'b1, 1'b0);
        check_output("bp_second_rd", 32'(rd_o), 32'd2);
        apply_stimulus(1'b1, 32'h002081B3, 32'h208, 32'd33, 32'd3, 1'b1, 1'b0);
        check_output("bp_third_rd", 32'(rd_o), 32'd3);
        check_output("bp_third_valid", 32'(out_valid_o), 32'd1);
        apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Illegal opcode: pulse for exactly one cycle, nothing forwarded
        apply_stimulus(1'b1, 32'h0000007F, 32'h300, 32'h0, 32'h0, 1'b1, 1'b0);
        check_output("ill_pulse", 32'(illegal_o), 32'd1);
        check_output("ill_no_valid", 32'(out_valid_o), 32'd0);
        apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_output("ill_pulse_end", 32'(illegal_o), 32'd0);

        // Flush while full, with a third instruction offered in the same cycle
        apply_stimulus(1'b1, 32'h002080B3, 32'h400, 32'd1, 32'd1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h00208133, 32'h404, 32'd2, 32'd2, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h002081B3, 32'h408, 32'd3, 32'd3, 1'b0, 1'b1);
        check_output("flush_valid", 32'(out_valid_o), 32'd0);
        check_output("flush_ready", 32'(in_ready_o), 32'd1);
        repeat (3) apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Illegal accept with a flush in the same cycle produces no pulse
        apply_stimulus(1'b1, 32'h0000007F, 32'h500, 32'h0, 32'h0, 1'b1, 1'b1);
        check_output("flush_ill_suppressed", 32'(illegal_o), 32'd0);

        // Reset mid-stream discards both entries and clears the data
        apply_stimulus(1'b1, 32'h002080B3, 32'h600, 32'd9, 32'd9, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h00208133, 32'h604, 32'd8, 32'd8, 1'b0, 1'b0);
        do_reset();

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(($urandom_range(0, 9) < 7), rand_instr(), $urandom, $urandom, $urandom,
                           ($urandom_range(0, 9) < 6), ($urandom_range(0, 39) == 0));
        end
        repeat (3) apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
